// File: rtl/sign_inject_unit.sv
// FPU sign-injection unit (FSGNJ / FSGNJN / FSGNJX) for single precision and,
// when FLEN=64, double precision with NaN-boxed singles. It shares the FPU
// valid/ready op bus and accepts only its own ops. Results are queued in a
// DEPTH-entry output FIFO, so a downstream stall only blocks issue once the
// FIFO is full.

package FPU_pkg;

  // Op codes on the shared FPU op bus.
  typedef enum logic [4:0] {
    FPU_OP_ADD    = 5'd0,
    FPU_OP_SUB    = 5'd1,
    FPU_OP_MUL    = 5'd2,
    FPU_OP_DIV    = 5'd3,
    FPU_OP_SQRT   = 5'd4,
    FPU_OP_SGNJ   = 5'd5,
    FPU_OP_SGNJN  = 5'd6,
    FPU_OP_SGNJX  = 5'd7,
    FPU_OP_MIN    = 5'd8,
    FPU_OP_MAX    = 5'd9,
    FPU_OP_CMP    = 5'd10,
    FPU_OP_CVT    = 5'd11,
    FPU_OP_CLASS  = 5'd12,
    FPU_OP_FMADD  = 5'd13
  } fpu_op_e;

endpackage : FPU_pkg

module sign_inject_unit
  import FPU_pkg::*;
#(
  parameter int FLEN  = 32,  // 32 or 64
  parameter int DEPTH = 2    // output FIFO entries, >= 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  output logic            ready_out,
  output logic            valid_out,
  input  logic            ready_in,
  input  logic [4:0]      op,
  input  logic            fmt,
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  output logic [FLEN-1:0] float_out
);

  // Pointer width (at least one bit so DEPTH=1 still has a legal vector)
  // and occupancy width (must represent 0..DEPTH inclusive).
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Canonical quiet NaN substituted for an improperly boxed single.
  localparam logic [31:0] QNAN_S = 32'h7FC0_0000;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Sign chosen by the op from the magnitude operand's sign and the sign
  // operand's sign; only the three sign-injection ops ever reach the FIFO.
  function automatic logic f_pick_sign(input logic [4:0] i_op,
                                       input logic       i_sa,
                                       input logic       i_sb);
    logic l_s;
    case (i_op)
      FPU_OP_SGNJN: l_s = ~i_sb;
      FPU_OP_SGNJX: l_s = i_sa ^ i_sb;
      default:      l_s = i_sb;
    endcase
    return l_s;
  endfunction

  // Circular increment: DEPTH need not be a power of two.
  function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] i_p);
    return (i_p == PW'(DEPTH - 1)) ? '0 : i_p + PW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Op decode and handshake
  // ---------------------------------------------------------------------------

  logic            w_is_sgnj;
  logic            w_op_ok;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [FLEN-1:0] w_result;

  logic [FLEN-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  assign w_is_sgnj = (op == FPU_OP_SGNJ) || (op == FPU_OP_SGNJN) ||
                     (op == FPU_OP_SGNJX);

  // A double-precision request cannot be served by a single-only build.
  assign w_op_ok   = w_is_sgnj && !(fmt && (FLEN == 32));

  assign w_full    = (r_count == CW'(DEPTH));

  // A full FIFO still accepts when its head leaves in the same cycle, so
  // ready_out has a combinational path from ready_in.
  assign ready_out = w_op_ok && (!w_full || ready_in);
  assign valid_out = (r_count != '0);

  assign w_push    = valid_in && ready_out;
  assign w_pop     = valid_out && ready_in;

  // ---------------------------------------------------------------------------
  // Result datapath
  // ---------------------------------------------------------------------------

  if (FLEN == 64) begin : g_dp64
    logic [31:0] w_a_s;
    logic [31:0] w_b_s;

    // Unbox singles and form the result for the selected format.
    // NOTE: every always_comb output gets a value on every path (here by
    // covering both fmt branches); a path that leaves one unassigned infers
    // a latch.
    always_comb begin
      w_a_s = (a[63:32] == 32'hFFFF_FFFF) ? a[31:0] : QNAN_S;
      w_b_s = (b[63:32] == 32'hFFFF_FFFF) ? b[31:0] : QNAN_S;
      if (fmt) begin
        w_result = {f_pick_sign(op, a[63], b[63]), a[62:0]};
      end else begin
        w_result = {32'hFFFF_FFFF, f_pick_sign(op, w_a_s[31], w_b_s[31]),
                    w_a_s[30:0]};
      end
    end
  end else begin : g_dp32
    // Single-only build: no boxing, sign bit is bit 31.
    assign w_result = {f_pick_sign(op, a[31], b[31]), a[30:0]};
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------

  // Store an accepted result at the write pointer.
  // NOTE: the storage array is deliberately not reset; an entry is only
  // observable while the count covers it, so clearing the count is enough
  // to drop every entry, and the array can map onto plain RAM/flops
  // without reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_result;
    end
  end

  // Advance pointers and occupancy; reset drops all entries at once.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= f_next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry is shown only while valid; otherwise the bus reads zero.
  assign float_out = valid_out ? r_mem[r_rd_ptr] : '0;

endmodule : sign_inject_unit

// File: tb/tb_sign_inject_unit.sv
// Testbench for sign_inject_unit: a FLEN=32 and a FLEN=64 instance (both
// DEPTH=2) share stimulus; sel routes valid_in to one of them. Expected
// results are pushed to a per-instance queue on each handshake and compared
// against the FIFO head every cycle.
module tb_sign_inject_unit;
  import FPU_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_in;
  logic        sel;       // 0 = FLEN=32 instance, 1 = FLEN=64 instance
  logic [4:0]  op;
  logic        fmt;
  logic [63:0] a;
  logic [63:0] b;

  logic        rdy32, vld32;
  logic [31:0] out32;
  logic        rdy64, vld64;
  logic [63:0] out64;

  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;
  logic rand_rdy = 1'b0;

  always #5 clk = ~clk;

  sign_inject_unit #(.FLEN(32), .DEPTH(DEPTH)) u_dut32 (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in && !sel),
    .ready_out (rdy32),
    .valid_out (vld32),
    .ready_in  (ready_in),
    .op        (op),
    .fmt       (fmt),
    .a         (a[31:0]),
    .b         (b[31:0]),
    .float_out (out32)
  );

  sign_inject_unit #(.FLEN(64), .DEPTH(DEPTH)) u_dut64 (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in && sel),
    .ready_out (rdy64),
    .valid_out (vld64),
    .ready_in  (ready_in),
    .op        (op),
    .fmt       (fmt),
    .a         (a),
    .b         (b),
    .float_out (out64)
  );

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference result of a sign-injection op for a given operand width.
  function automatic logic [63:0] model(input int flen, input logic [4:0] o,
                                        input logic f, input logic [63:0] x,
                                        input logic [63:0] y);
    logic [31:0] xs;
    logic [31:0] ys;
    logic sa, sb, s;
    xs = x[31:0];
    ys = y[31:0];
    if (flen == 64 && !f) begin
      xs = (x[63:32] == 32'hFFFFFFFF) ? x[31:0] : 32'h7FC00000;
      ys = (y[63:32] == 32'hFFFFFFFF) ? y[31:0] : 32'h7FC00000;
    end
    if (flen == 64 && f) begin
      sa = x[63];
      sb = y[63];
    end else begin
      sa = xs[31];
      sb = ys[31];
    end
    case (o)
      FPU_OP_SGNJ:  s = sb;
      FPU_OP_SGNJN: s = ~sb;
      default:      s = sa ^ sb;
    endcase
    if (flen == 64 && f) return {s, x[62:0]};
    if (flen == 64)      return {32'hFFFFFFFF, s, xs[30:0]};
    return {32'h0, s, xs[30:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake model and scoreboards
  // ---------------------------------------------------------------------------
  logic [63:0] cur_exp32, cur_exp64;
  int          cnt32, cnt64;
  logic [63:0] q32[$];
  logic [63:0] q64[$];

  wire sgnj      = (op == FPU_OP_SGNJ) || (op == FPU_OP_SGNJN) || (op == FPU_OP_SGNJX);
  wire exp_rdy32 = sgnj && !fmt && (cnt32 < DEPTH || ready_in);
  wire exp_rdy64 = sgnj && (cnt64 < DEPTH || ready_in);
  wire push32    = valid_in && !sel && exp_rdy32;
  wire push64    = valid_in && sel && exp_rdy64;
  wire pop32     = (cnt32 != 0) && ready_in;
  wire pop64     = (cnt64 != 0) && ready_in;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt32 <= 0;
      cnt64 <= 0;
      q32.delete();
      q64.delete();
    end else begin
      if (pop32) void'(q32.pop_front());
      if (push32) q32.push_back(cur_exp32);
      if (pop64) void'(q64.pop_front());
      if (push64) q64.push_back(cur_exp64);
      cnt32 <= cnt32 + int'(push32) - int'(pop32);
      cnt64 <= cnt64 + int'(push64) - int'(pop64);
    end
  end

  // Compare handshake outputs and the FIFO head every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("rdy32", rdy32, exp_rdy32);
      check("vld32", vld32, cnt32 != 0);
      check("out32", out32, (cnt32 != 0 && q32.size() != 0) ? q32[0] : 64'h0);
      check("rdy64", rdy64, exp_rdy64);
      check("vld64", vld64, cnt64 != 0);
      check("out64", out64, (cnt64 != 0 && q64.size() != 0) ? q64[0] : 64'h0);
    end
  end

  // Random downstream back-pressure for the mixed phase.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 ready_in = 1'($urandom_range(0, 1));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op and hold it until accepted (bounded).
  task automatic send(input logic s, input logic [4:0] o, input logic f,
                      input logic [63:0] x, input logic [63:0] y,
                      input logic use_given = 1'b0,
                      input logic [63:0] given = 64'h0);
    logic acc;
    acc       = 1'b0;
    sel       = s;
    op        = o;
    fmt       = f;
    a         = x;
    b         = y;
    cur_exp32 = model(32, o, f, x, y);
    cur_exp64 = model(64, o, f, x, y);
    if (use_given) begin
      if (s) cur_exp64 = given;
      else   cur_exp32 = given;
    end
    valid_in = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(posedge clk);
      acc = s ? push64 : push32;
      #1;
    end
    valid_in = 1'b0;
    check("send_accept", acc, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    time t0;
    logic [4:0] ops [3];
    logic [63:0] exp_b;
    ops[0] = FPU_OP_SGNJ;
    ops[1] = FPU_OP_SGNJN;
    ops[2] = FPU_OP_SGNJX;

    reset = 1'b1; valid_in = 1'b0; ready_in = 1'b0; sel = 1'b0;
    op = FPU_OP_SGNJ; fmt = 1'b0; a = '0; b = '0;
    cur_exp32 = '0; cur_exp64 = '0;
    #12;
    check("rst_vld", vld64, 1'b0);
    check("rst_out", out64, 64'h0);
    check("rst_rdy", rdy64, 1'b1);
    step();
    reset = 1'b0;
    mon_en = 1'b1;
    step();

    // Known vectors, read one cycle after acceptance.
    ready_in = 1'b1;
    send(1'b0, FPU_OP_SGNJ, 1'b0, 64'h3F800000, 64'hC0000000, 1'b1, 64'hBF800000);
    check("vec_sgnj32", out32, 64'hBF800000);
    check("vec_lat32", vld32, 1'b1);
    send(1'b0, FPU_OP_SGNJN, 1'b0, 64'h3F800000, 64'h40000000, 1'b1, 64'hBF800000);
    check("vec_sgnjn32", out32, 64'hBF800000);
    send(1'b0, FPU_OP_SGNJX, 1'b0, 64'hBF800000, 64'hC0000000, 1'b1, 64'h3F800000);
    check("vec_sgnjx32", out32, 64'h3F800000);
    send(1'b1, FPU_OP_SGNJ, 1'b0, 64'h00000000_3F800000, 64'hFFFFFFFF_BF800000,
         1'b1, 64'hFFFFFFFF_FFC00000);
    check("vec_box64", out64, 64'hFFFFFFFF_FFC00000);
    send(1'b1, FPU_OP_SGNJN, 1'b1, 64'h3FF00000_00000000, 64'h80000000_00000000,
         1'b1, 64'h3FF00000_00000000);
    check("vec_d64", out64, 64'h3FF00000_00000000);
    step();

    // Foreign op and double on the single-only build are refused.
    sel = 1'b1; op = FPU_OP_ADD; valid_in = 1'b1;
    repeat (3) step();
    check("add_rdy", rdy64, 1'b0);
    check("add_vld", vld64, 1'b0);
    sel = 1'b0; op = FPU_OP_SGNJ; fmt = 1'b1;
    repeat (2) step();
    check("d_on_32_rdy", rdy32, 1'b0);
    valid_in = 1'b0; fmt = 1'b0;
    step();

    // Fill with ready_in low; third op is held until ready_in rises.
    ready_in = 1'b0;
    send(1'b1, FPU_OP_SGNJ, 1'b1, 64'h11111111_00000001, 64'h80000000_00000000);
    send(1'b1, FPU_OP_SGNJN, 1'b1, 64'h22222222_00000002, 64'h00000000_00000000);
    exp_b = model(64, FPU_OP_SGNJN, 1'b1, 64'h22222222_00000002, 64'h0);
    check("full_rdy", rdy64, 1'b0);
    fork
      send(1'b1, FPU_OP_SGNJX, 1'b1, 64'hB3333333_00000003, 64'h80000000_00000000);
      begin
        repeat (3) step();
        ready_in = 1'b1;
      end
    join
    check("hold_head", out64, exp_b);
    repeat (3) step();

    // Streaming: one result per cycle with ready_in held high.
    t0 = $time;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, ops[i % 3], 1'((i >> 1) & 1),
           {32'hFFFFFFFF - 32'(i & 1), 32'h40000000 + 32'(i * 32'h01010101)},
           {32'h80000000 * 32'(i & 1), 32'(i) << 29});
    end
    check("tput_time", 64'($time - t0), 64'd80);
    repeat (3) step();

    // Mixed traffic with random back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic s;
      logic f;
      logic [63:0] x;
      logic [63:0] y;
      s = 1'($urandom_range(0, 1));
      f = s ? 1'($urandom_range(0, 1)) : 1'b0;
      x = {($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : $urandom(), $urandom()};
      y = {($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : $urandom(), $urandom()};
      send(s, ops[$urandom_range(0, 2)], f, x, y);
    end
    rand_rdy = 1'b0;
    step();
    ready_in = 1'b1;
    repeat (4) step();

    // Asynchronous reset with two stored entries.
    ready_in = 1'b0;
    send(1'b1, FPU_OP_SGNJ, 1'b1, 64'h55555555_00000005, 64'h0);
    send(1'b1, FPU_OP_SGNJ, 1'b1, 64'h66666666_00000006, 64'h0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_vld", vld64, 1'b0);
    check("arst_out", out64, 64'h0);
    step();
    step();
    reset = 1'b0;
    step();
    check("post_rst_vld", vld64, 1'b0);
    ready_in = 1'b1;
    send(1'b1, FPU_OP_SGNJX, 1'b1, 64'h3FF00000_00000000, 64'h80000000_00000000,
         1'b1, 64'hBFF00000_00000000);
    check("post_rst_out", out64, 64'hBFF00000_00000000);
    repeat (3) step();
    check("drain_vld", vld64, 1'b0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_sign_inject_unit
